// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller: arbitrates ID/EX/MEM stall requests,
// defers exception flushes behind in-flight memory accesses, and tracks stall statistics.
module pipe_stall_ctrl #(
  parameter int STALL_W = 5,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stallreq_i,
  input  logic               ex_stallreq_i,
  input  logic               mem_stallreq_i,
  input  logic               excp_i,
  input  logic [31:0]        excp_pc_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic               timeout_o
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MEM = {{(STALL_W-1){1'b1}}, 1'b0};
  localparam logic [STALL_W-1:0] STALL_EX  = {{(STALL_W-2){1'b1}}, 2'b00};
  localparam logic [STALL_W-1:0] STALL_ID  = {{(STALL_W-3){1'b1}}, 3'b000};

  typedef enum logic [1:0] {RUN, FLUSH_PEND, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q;
  logic             stalled;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      pend_pc_q <= '0;
      new_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      new_pc_q  <= new_pc_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    new_pc_d  = new_pc_q;
    unique case (state_q)
      RUN: begin
        if (excp_i) begin
          pend_pc_d = excp_pc_i;
          if (mem_stallreq_i) begin
            state_d = FLUSH_PEND;
          end else begin
            state_d  = FLUSH;
            new_pc_d = excp_pc_i;
          end
        end
      end
      FLUSH_PEND: begin
        if (!mem_stallreq_i) begin
          state_d  = FLUSH;
          new_pc_d = pend_pc_q;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_o = '0;
    flush_o = 1'b0;
    unique case (state_q)
      FLUSH:      flush_o = 1'b1;
      FLUSH_PEND: stall_o = STALL_MEM;
      default: begin
        if (mem_stallreq_i)     stall_o = STALL_MEM;
        else if (ex_stallreq_i) stall_o = STALL_EX;
        else if (id_stallreq_i) stall_o = STALL_ID;
      end
    endcase
    // Outputs must sit at reset values while reset is held, even with requests active.
    if (!rst) stall_o = '0;
  end

  assign stalled = |stall_o;
  assign run_d   = !stalled ? '0 :
                   (run_q == RUN_W'(TIMEOUT)) ? run_q : run_q + RUN_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + CNT_W'(stalled);
      run_q     <= run_d;
      timeout_q <= timeout_q | (run_d == RUN_W'(TIMEOUT));
    end
  end

  assign new_pc_o    = new_pc_q;
  assign stall_cnt_o = cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by random
// requests, compared cycle by cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_r, ex_r, mem_r, excp_r;
  logic [31:0] pc_r;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cnt_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = normal, 1 = exception waiting on memory, 2 = flushing this cycle
  int          m_mode;
  logic [31:0] m_latch, m_newpc, m_cnt;
  int          m_run;
  bit          m_tout;

  pipe_stall_ctrl #(.STALL_W(5), .TIMEOUT(T), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .id_stallreq_i  (id_r),
    .ex_stallreq_i  (ex_r),
    .mem_stallreq_i (mem_r),
    .excp_i         (excp_r),
    .excp_pc_i      (pc_r),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_cnt_o    (stall_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_stall();
    if (m_mode == 2) return 5'b00000;
    if (m_mode == 1) return 5'b11110;
    if (mem_r) return 5'b11110;
    if (ex_r)  return 5'b11100;
    if (id_r)  return 5'b11000;
    return 5'b00000;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_latch = '0; m_newpc = '0; m_cnt = '0; m_run = 0; m_tout = 0;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] es;
    es = exp_stall();
    check({tag, ".stall"}, 32'(stall_o), 32'(es));
    check({tag, ".flush"}, 32'(flush_o), 32'(m_mode == 2));
    check({tag, ".new_pc"}, new_pc_o, m_newpc);
    check({tag, ".cnt"}, stall_cnt_o, m_cnt);
    check({tag, ".tout"}, 32'(timeout_o), 32'(m_tout));
  endtask

  // Called at posedge+1: drive, check at negedge, advance model at the next posedge.
  task automatic step(input string tag, input bit id, input bit ex, input bit mem,
                      input bit excp, input logic [31:0] pc);
    logic [4:0] es;
    id_r = id; ex_r = ex; mem_r = mem; excp_r = excp; pc_r = pc;
    @(negedge clk);
    check_all(tag);
    es = exp_stall();
    @(posedge clk);
    if (es != 0) begin
      m_cnt++;
      m_run = (m_run < T) ? m_run + 1 : T;
    end else begin
      m_run = 0;
    end
    if (m_run >= T) m_tout = 1;
    case (m_mode)
      2: m_mode = 0;
      1: if (!mem) begin m_mode = 2; m_newpc = m_latch; end
      default: if (excp) begin
        m_latch = pc;
        if (mem) m_mode = 1;
        else begin m_mode = 2; m_newpc = pc; end
      end
    endcase
    #1;
  endtask

  // Asserts reset mid-cycle with requests still active, then releases cleanly.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_stall"}, 32'(stall_o), 32'h0);
    check({tag, ".rst_flush"}, 32'(flush_o), 32'h0);
    check({tag, ".rst_pc"}, new_pc_o, 32'h0);
    check({tag, ".rst_cnt"}, stall_cnt_o, 32'h0);
    check({tag, ".rst_tout"}, 32'(timeout_o), 32'h0);
    id_r = 0; ex_r = 0; mem_r = 0; excp_r = 0; pc_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_r = 0; ex_r = 0; mem_r = 0; excp_r = 0; pc_r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, '0);

    step("id1", 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("ex3", 0, 1, 0, 0, '0);
    step("after_ex", 0, 0, 0, 0, '0);

    step("all_req", 1, 1, 1, 0, '0);
    step("drop_mem", 1, 1, 0, 0, '0);
    step("idle2", 0, 0, 0, 0, '0);

    step("excp", 0, 0, 0, 1, 32'hBFC0_0380);
    step("flush", 1, 1, 0, 0, '0);
    step("post_flush", 0, 0, 0, 0, '0);

    step("pend0", 0, 0, 1, 1, 32'h8000_0100);
    step("pend1", 0, 0, 1, 1, 32'hDEAD_BEEF);
    step("pend2", 1, 1, 1, 0, '0);
    step("pend3", 0, 0, 1, 0, '0);
    step("pend_low", 0, 1, 0, 0, '0);
    step("pend_flush", 0, 1, 0, 1, 32'h1234_5678);
    step("pend_run", 0, 0, 0, 0, '0);

    for (int i = 0; i < T; i++) step("wd_ex", 0, 1, 0, 0, '0);
    step("wd_drop", 0, 0, 0, 0, '0);
    step("wd_hold", 0, 0, 0, 0, '0);
    ex_r = 1'b1;
    async_reset("wd");
    step("wd_after", 0, 0, 0, 0, '0);

    step("rp_excp", 0, 0, 1, 1, 32'hCAFE_0000);
    step("rp_wait", 0, 0, 1, 0, '0);
    mem_r = 1'b1;
    async_reset("rp");
    step("rp_after0", 0, 0, 0, 0, '0);
    step("rp_after1", 0, 0, 0, 0, '0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rnd");
      step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline control unit that produces the stall vector consumed by every pipeline register (PC, If2Id, Id2Ex, Ex2Mem, Mem2Wb) and the flush/redirect for exceptions. It arbitrates stall requests from the ID stage (load-use), the EX stage (multi-cycle divide/multiply) and the MEM stage (data-bus wait). It defers exception flushes until an in-flight memory access completes. It also keeps a stall-cycle performance counter and a stall watchdog.

Parameters:
STALL_W, 5, stall vector width; bit0 Mem2Wb, bit1 Ex2Mem, bit2 Id2Ex, bit3 If2Id, bit4 PC
TIMEOUT, 1024, consecutive stalled cycles before watchdog trips
CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
id_stallreq_i  input  1  load-use hazard request from ID
ex_stallreq_i  input  1  multi-cycle op busy in EX
mem_stallreq_i  input  1  data bus not ready in MEM
excp_i  input  1  exception detected in MEM, single-cycle pulse
excp_pc_i  input  32  handler entry address accompanying excp_i
stall_o  output  STALL_W  stall vector, 1 = Stop
flush_o  output  1  clear all pipeline registers, one cycle
new_pc_o  output  32  redirect target, valid when flush_o=1
stall_cnt_o  output  CNT_W  total cycles with stall_o!=0
timeout_o  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): FSM=RUN; stall_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0, timeout_o=0, pending PC=0, run-length counter=0.
- stall_o is combinational from the requests and FSM state, in the same cycle. Priority is MEM > EX > ID:
  - mem_stallreq_i=1 -> 5'b11110
  - else ex_stallreq_i=1 -> 5'b11100
  - else id_stallreq_i=1 -> 5'b11000
  - else 5'b00000
- Bubble rule for consumers: a register whose upstream bit is Stop and whose own bit is NotStop loads a bubble.
- FSM states: RUN, FLUSH_PEND, FLUSH.
  - RUN, excp_i=1 and mem_stallreq_i=0 -> FLUSH; latch excp_pc_i.
  - RUN, excp_i=1 and mem_stallreq_i=1 -> FLUSH_PEND; latch excp_pc_i.
  - FLUSH_PEND: stall_o=5'b11110 regardless of other requests; later excp_i ignored; -> FLUSH in the cycle after mem_stallreq_i is first seen low.
  - FLUSH: flush_o=1, new_pc_o=latched PC, stall_o=0 (flush overrides id/ex requests); -> RUN after exactly one cycle.
- Outside FLUSH, flush_o=0 and new_pc_o holds its last value.
- excp_i while in FLUSH is ignored; excp_i coincident with id/ex requests follows the RUN rules above.
- stall_cnt_o increments by 1 on each clk edge where stall_o!=0; wraps from all-ones to 0.
- Watchdog run-length counter:
  - increments while stall_o!=0, clears when stall_o==0; saturates at TIMEOUT.
  - reaching TIMEOUT sets timeout_o=1, which stays set until reset.
- Asserting reset mid-FLUSH_PEND or mid-stall discards the pending flush and the counts; outputs reach reset values without waiting for clk.

Test Plan:
- Reset release, no requests -> stall_o=00000, flush_o=0, stall_cnt_o stays 0 over 10 cycles.
- id_stallreq_i=1 for 1 cycle -> stall_o=11000 that cycle, stall_cnt_o=1; ex_stallreq_i=1 for 3 cycles -> 11100 ×3, count 4.
- id, ex and mem requests all asserted together -> stall_o=11110; drop mem only -> 11100 same cycle.
- excp_i with excp_pc_i=0xBFC00380, no mem stall -> next cycle flush_o=1, new_pc_o=0xBFC00380, stall_o=0; following cycle flush_o=0.
- mem_stallreq_i high 4 cycles, excp_i in the first of them -> stall_o=11110 throughout; flush_o=1 one cycle after mem_stallreq_i falls; a second excp_i during the wait is ignored.
- TIMEOUT=8, ex_stallreq_i held 8 cycles -> timeout_o=1 and stays set after the request drops; async rst low mid-cycle -> timeout_o=0 immediately.
